rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, meaning the number of sequenced reset outputs (legal 1..8).
REQ-002 SHALL have parameter STAGE_DELAY, default 256, meaning clk_in cycles between successive stage releases (legal >=1).
REQ-003 SHALL have parameter WDT_CYCLES, default 1048576, meaning the watchdog timeout in clk_in cycles (legal >=2).
REQ-004 SHALL have port clk_in  input  1  single clock: the PLL core output clock; all logic runs on its rising edge.
REQ-005 SHALL have port resetb_in  input  1  reset, asynchronous assert, active-low: the PLL's buffered reset output.
REQ-006 SHALL have port soft_rst  input  1  synchronous request to re-sequence all stages; level-sensitive.
REQ-007 SHALL have port wdt_kick  input  1  watchdog service pulse, sampled each cycle.
REQ-008 SHALL have port rst_n_out  output  NUM_STAGES  per-stage active-low resets; bit 0 is released first.
REQ-009 SHALL have port ready  output  1  high when all stages are released and state is RUN.
REQ-010 SHALL have port wdt_fired  output  1  sticky flag: the watchdog has triggered since the last resetb_in.

Function
REQ-011 SHALL implement states HOLD and RUN: HOLD releases stages one at a time; RUN means all stages are released.
REQ-012 SHALL, in HOLD, increment a delay counter each cycle; when counter==STAGE_DELAY-1, release the lowest still-asserted stage bit at that edge and clear the counter.
REQ-013 SHALL give this timing after resetb_in deasserts, with edge 1 being the first rising edge: rst_n_out[k] rises at edge (k+1)*STAGE_DELAY.
REQ-014 SHALL, on the edge that releases bit NUM_STAGES-1, leave the counter cleared and enter RUN on the following edge; ready rises at edge NUM_STAGES*STAGE_DELAY+1.
REQ-015 SHALL keep released bits monotonic: no bit deasserts before a lower-index bit.
REQ-016 SHALL, on any edge with soft_rst=1 in any state, drive all rst_n_out=0 and ready=0, clear the delay counter, and enter HOLD.
REQ-017 SHALL, while soft_rst is held high, keep the counter at 0 and release nothing; sequencing restarts on the first edge after soft_rst falls, with the same timing as REQ-013.
REQ-018 SHALL give soft_rst priority over a stage release or RUN entry scheduled for the same edge.
REQ-019 SHALL drive outputs directly from flops, with no combinational path from any input to any output.

Reset
REQ-020 SHALL, while resetb_in=0, immediately force rst_n_out=0, ready=0, wdt_fired=0, all counters to 0, and state HOLD, independent of clk_in.
REQ-021 SHALL, if resetb_in asserts mid-sequence or in RUN, abandon all progress; no partial release survives.

Configuration
REQ-022 SHALL compile the watchdog in only when macro RST_SEQ_WDT_EN is defined.
REQ-023 SHALL, with RST_SEQ_WDT_EN defined, behave as follows:
- The watchdog counter runs only in RUN.
- It clears on RUN entry and on wdt_kick=1.
- When the count equals WDT_CYCLES-1 with no kick that cycle, the block performs the REQ-016 action and sets wdt_fired=1.
- A kick on the timeout cycle wins.
- soft_rst on the same edge as a timeout still sets wdt_fired.
REQ-024 SHALL, without RST_SEQ_WDT_EN, omit the watchdog counter, ignore wdt_kick, and tie wdt_fired to 0.

Verification
REQ-025 SHALL cover power-up: NUM_STAGES=3, STAGE_DELAY=4, resetb_in released before edge 1 -> rst_n_out 001 at edge 4, 011 at edge 8, 111 at edge 12, ready=1 at edge 13.
REQ-026 SHALL cover a soft_rst one-cycle pulse at edge 20 in RUN -> at edge 20 outputs 000 and ready 0; 001 at edge 24, 111 at edge 32, ready at edge 33.
REQ-027 SHALL cover soft_rst asserted on edge 8, the bit-1 release edge -> rst_n_out stays 000; with soft_rst high for 3 edges (8-10) then low, the first release is at edge 14.
REQ-028 SHALL cover resetb_in pulsed low between edges 9 and 10 -> all outputs 0 asynchronously, then the REQ-025 timing counted from the next edge.
REQ-029 SHALL cover the watchdog with RST_SEQ_WDT_EN defined, WDT_CYCLES=16, no kicks -> at edge 29 outputs 000 and wdt_fired=1; 001 at edge 33; wdt_fired stays 1 until resetb_in.
REQ-030 SHALL cover watchdog service with RST_SEQ_WDT_EN defined: a kick every 10 cycles -> no trigger over 1000 cycles. Without the macro: no kicks for 1000 cycles -> ready stays 1 and wdt_fired stays 0.

Source files
------------

// File: rtl/rst_seq.sv
// rst_seq: releases NUM_STAGES active-low resets one per STAGE_DELAY cycles after resetb_in.
// An optional run-time watchdog is compiled in with RST_SEQ_WDT_EN.
module rst_seq #(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 256,
  parameter int WDT_CYCLES  = 1048576
) (
  input  logic                  clk_in,
  input  logic                  resetb_in,
  input  logic                  soft_rst,
  input  logic                  wdt_kick,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  ready,
  output logic                  wdt_fired
);
  localparam int CW = STAGE_DELAY > 1 ? $clog2(STAGE_DELAY) : 1;
  localparam int WW = $clog2(WDT_CYCLES);
  typedef enum logic {HOLD, RUN} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  wdt_to;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    if (state_q == HOLD) begin
      if (&stage_q) state_d = RUN;
      else if (cnt_q == CW'(STAGE_DELAY - 1)) begin
        cnt_d   = '0;
        stage_d = (stage_q << 1) | NUM_STAGES'(1);
      end else cnt_d = cnt_q + CW'(1);
    end
    if (soft_rst || wdt_to) begin
      state_d = HOLD;
      cnt_d   = '0;
      stage_d = '0;
    end
  end
  always_ff @(posedge clk_in or negedge resetb_in) begin
    if (!resetb_in) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
    end
  end
  assign rst_n_out = stage_q;
  assign ready     = state_q == RUN;
`ifdef RST_SEQ_WDT_EN
  logic [WW-1:0] wdt_q, wdt_d;
  logic          fired_q;
  // A kick on the terminal count suppresses the timeout.
  assign wdt_to = state_q == RUN && !wdt_kick && wdt_q == WW'(WDT_CYCLES - 1);
  assign wdt_d  = (state_q != RUN || wdt_kick || wdt_to) ? '0 : wdt_q + WW'(1);
  always_ff @(posedge clk_in or negedge resetb_in) begin
    if (!resetb_in) begin
      wdt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      wdt_q   <= wdt_d;
      fired_q <= fired_q | wdt_to;
    end
  end
  assign wdt_fired = fired_q;
`else
  logic          unused_kick;
  logic [WW-1:0] unused_wdt;
  assign unused_kick = wdt_kick;
  assign unused_wdt  = WW'(WDT_CYCLES - 1);
  assign wdt_to      = 1'b0;
  assign wdt_fired   = 1'b0;
`endif
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: randomized scoreboard bench for rst_seq; the model counts edges since the last restart.
module tb_rst_seq;
  localparam int N = 3, D = 4, W = 16;
`ifdef RST_SEQ_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif
  logic         clk_in = 1'b0, resetb_in = 1'b0, soft_rst = 1'b0, wdt_kick = 1'b0;
  logic [N-1:0] rst_n_out;
  logic         ready, wdt_fired;
  logic [N+1:0] q[$];
  int           checks = 0, failures = 0;
  int           k = 0, clr = 0;
  bit           fired = 1'b0;

  rst_seq #(.NUM_STAGES(N), .STAGE_DELAY(D), .WDT_CYCLES(W)) dut (
    .clk_in(clk_in), .resetb_in(resetb_in), .soft_rst(soft_rst), .wdt_kick(wdt_kick),
    .rst_n_out(rst_n_out), .ready(ready), .wdt_fired(wdt_fired)
  );

  always #5 clk_in = ~clk_in;

  // k = rising edges since resetb_in release or the last soft/watchdog restart.
  function automatic logic [N+1:0] expv();
    int rel = k / D;
    if (rel > N) rel = N;
    return {N'((1 << rel) - 1), k >= N * D + 1, fired};
  endfunction

  task automatic cycle(input bit s, input bit kick);
    bit run, to;
    soft_rst = s;
    wdt_kick = kick;
    run = k >= N * D + 1;
    to  = WDT && run && !kick && (k - clr == W - 1);
    if (s || to) begin
      k = 0;
      fired = fired | to;
    end else begin
      k++;
      if (k == N * D + 1 || (run && kick)) clr = k;
    end
    q.push_back(expv());
    @(negedge clk_in);
    #1;
  endtask

  task automatic pulse();
    resetb_in = 1'b0;
    #2;
    resetb_in = 1'b1;
    k = 0;
    clr = 0;
    fired = 1'b0;
  endtask

  always begin
    logic [N+1:0] e;
    @(negedge clk_in or negedge resetb_in);
    if (!resetb_in) begin
      #1;
      checks++;
      if ({rst_n_out, ready, wdt_fired} !== '0) begin
        failures++;
        $display("FAIL async_rst got=%b required=%b", {rst_n_out, ready, wdt_fired}, {(N+2){1'b0}});
      end
    end else if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({rst_n_out, ready, wdt_fired} !== e) begin
        failures++;
        $display("FAIL seq t=%0t got rst/ready/fired=%b required=%b", $time, {rst_n_out, ready, wdt_fired}, e);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk_in);
    #1;
    resetb_in = 1'b1;
    for (int e = 1; e <= 40; e++) cycle(e == 20, 1'b0);
    pulse();
    for (int e = 1; e <= 20; e++) cycle(e >= 8 && e <= 10, 1'b0);
    pulse();
    for (int e = 1; e <= 9; e++) cycle(1'b0, 1'b0);
    pulse();
    for (int e = 1; e <= 16; e++) cycle(1'b0, 1'b0);
    pulse();
    for (int e = 1; e <= 50; e++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) pulse();
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 13) == 0);
    end
    pulse();
    for (int i = 0; i <= 1000; i++) cycle(1'b0, WDT && (i % 10 == 0));
    pulse();
    for (int e = 1; e <= 60; e++) cycle(1'b0, 1'b0);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
